// File: rtl/riscv_mc_sequencer.sv
// riscv_mc_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for
// the RISC-V core. It drives one shared variable-latency memory port through a
// req/ack handshake, halts on an all-zero instruction, and flags an error on
// memory timeout or illegal opcode. It also keeps saturating counters of busy
// cycles and retired instructions.
module riscv_mc_sequencer #(
    parameter int XLEN     = 32,
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst,        // synchronous, active-low
    input  logic             start,
    input  logic [XLEN-1:0]  ir,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_wr,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic             reg_write,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    // The wait counter only needs to reach MAX_WAIT-1: the cycle in which it
    // holds that value is the last one an ack is still accepted.
    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_ERROR
    } state_e;

    // Instruction class captured in DECODE so EXEC/MEM do not depend on ir
    // staying stable after decode.
    typedef enum logic [1:0] {
        K_ALU,
        K_BRANCH,
        K_LOAD,
        K_STORE
    } kind_e;

    state_e            state_q, state_d;
    kind_e             kind_q,  kind_d;
    logic [WAIT_W-1:0] wait_q,  wait_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;

    logic              ir_zero;
    logic              ir_legal;
    kind_e             ir_kind;
    logic              timeout;
    logic              cnt_clear;

    assign ir_zero   = (ir == '0);
    assign timeout   = (wait_q == WAIT_W'(MAX_WAIT - 1));
    assign cnt_clear = ((state_q == S_IDLE) || (state_q == S_HALT)) && start;

    // Classify the opcode field of the instruction register.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        ir_legal = 1'b0;
        ir_kind  = K_ALU;
        case (ir[6:0])
            OP_LOAD:   begin ir_legal = 1'b1; ir_kind = K_LOAD;   end
            OP_STORE:  begin ir_legal = 1'b1; ir_kind = K_STORE;  end
            OP_BRANCH: begin ir_legal = 1'b1; ir_kind = K_BRANCH; end
            OP_RTYPE, OP_IALU, OP_LUI, OP_JAL, OP_JALR: begin
                ir_legal = 1'b1;
                ir_kind  = K_ALU;
            end
            default:   ir_legal = 1'b0;
        endcase
    end

    // Next-state and output decode; ir_we and the store-path pc_we are the
    // only outputs gated by mem_ack in the same cycle.
    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        wait_d    = '0;
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        reg_write = 1'b0;
        done      = 1'b0;
        err       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end

            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            S_DECODE: begin
                if (ir_zero) begin
                    state_d = S_HALT;
                end else if (ir_legal) begin
                    kind_d  = ir_kind;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_ERROR;
                end
            end

            S_EXEC: begin
                case (kind_q)
                    K_BRANCH: begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end
                    K_LOAD, K_STORE: state_d = S_MEM;
                    default:         state_d = S_WB;
                endcase
            end

            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_wr   = (kind_q == K_STORE);
                if (mem_ack) begin
                    if (kind_q == K_STORE) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            S_WB: begin
                reg_write = 1'b1;
                pc_we     = 1'b1;
                state_d   = S_FETCH;
            end

            S_HALT: begin
                done = 1'b1;
                if (start) state_d = S_FETCH;
            end

            S_ERROR: begin
                err = 1'b1;
            end

            default: state_d = S_ERROR;
        endcase
    end

    assign busy = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                  (state_q == S_EXEC)  || (state_q == S_MEM)    ||
                  (state_q == S_WB);

    // Saturating performance counters; cleared when a run is (re)started.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (cnt_clear) begin
            cycle_cnt_d = '0;
            instr_cnt_d = '0;
        end else begin
            if (busy && (cycle_cnt_q != {CNT_W{1'b1}}))
                cycle_cnt_d = cycle_cnt_q + 1'b1;
            if (pc_we && (instr_cnt_q != {CNT_W{1'b1}}))
                instr_cnt_d = instr_cnt_q + 1'b1;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of its peers.
        if (!rst) begin
            state_q     <= S_IDLE;
            kind_q      <= K_ALU;
            wait_q      <= '0;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            wait_q      <= wait_d;
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_riscv_mc_sequencer.sv
// Directed bench for riscv_mc_sequencer. The bench acts as the memory: each
// access is acknowledged after a chosen number of wait cycles. A second
// instance with CNT_W=4 shares all inputs to exercise counter saturation.
module tb_riscv_mc_sequencer;

    localparam logic [31:0] I_ADDI = 32'h0050_0093;  // addi x1,x0,5
    localparam logic [31:0] I_ADD  = 32'h0010_8133;  // add  x2,x1,x1
    localparam logic [31:0] I_SW   = 32'h0020_2023;  // sw   x2,0(x0)
    localparam logic [31:0] I_LW   = 32'h0000_2183;  // lw   x3,0(x0)
    localparam logic [31:0] I_BEQ  = 32'h0000_0063;  // beq  x0,x0,0
    localparam logic [31:0] I_HALT = 32'h0000_0000;
    localparam logic [31:0] I_ILL  = 32'h0000_007F;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] ir;
    logic        mem_ack;

    logic        mem_req, mem_wr, addr_sel, ir_we, pc_we, reg_write;
    logic        busy, done, err;
    logic [31:0] cycle_cnt, instr_cnt;

    logic        s_mem_req, s_mem_wr, s_addr_sel, s_ir_we, s_pc_we, s_reg_write;
    logic        s_busy, s_done, s_err;
    logic [3:0]  s_cycle_cnt, s_instr_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Per-run observation counters, cleared by the test steps.
    int req_cnt, mreq_cnt, wr_cnt, pc_pulses, rw_pulses, irwe_cnt;
    int cyc;

    riscv_mc_sequencer #(.XLEN(32), .CNT_W(32), .MAX_WAIT(15)) dut (
        .clk(clk), .rst(rst), .start(start), .ir(ir), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_wr(mem_wr), .addr_sel(addr_sel),
        .ir_we(ir_we), .pc_we(pc_we), .reg_write(reg_write),
        .busy(busy), .done(done), .err(err),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    riscv_mc_sequencer #(.XLEN(32), .CNT_W(4), .MAX_WAIT(15)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .ir(ir), .mem_ack(mem_ack),
        .mem_req(s_mem_req), .mem_wr(s_mem_wr), .addr_sel(s_addr_sel),
        .ir_we(s_ir_we), .pc_we(s_pc_we), .reg_write(s_reg_write),
        .busy(s_busy), .done(s_done), .err(s_err),
        .cycle_cnt(s_cycle_cnt), .instr_cnt(s_instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] flags();
        return {mem_req, mem_wr, addr_sel, ir_we, pc_we, reg_write, busy, done, err};
    endfunction

    task automatic clear_obs();
        req_cnt = 0; mreq_cnt = 0; wr_cnt = 0;
        pc_pulses = 0; rw_pulses = 0; irwe_cnt = 0;
    endtask

    // Bench is always positioned just after a falling edge.
    task automatic step();
        #1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; mem_ack = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Runs one instruction: fetch acked after fwait wait cycles, data access
    // after mwait. Returns when it retires, halts or errors.
    task automatic run_instr(input logic [31:0] instr, input int fwait, input int mwait);
        int  waits;
        bit  fetched;
        bit  stop;
        waits   = 0;
        fetched = 1'b0;
        cyc     = 0;
        ir      = instr;
        for (int k = 0; k < 200; k++) begin
            mem_ack = mem_req && (waits == (fetched ? mwait : fwait));
            #1;
            if (busy)               cyc++;
            if (pc_we)              pc_pulses++;
            if (reg_write)          rw_pulses++;
            if (ir_we)              irwe_cnt++;
            if (mem_req)            req_cnt++;
            if (mem_req && addr_sel) mreq_cnt++;
            if (mem_req && mem_wr)  wr_cnt++;
            stop = pc_we || done || err;
            if (mem_req) begin
                if (mem_ack) begin
                    fetched = 1'b1;
                    waits   = 0;
                end else begin
                    waits++;
                end
            end
            @(negedge clk);
            mem_ack = 1'b0;
            if (stop) return;
        end
        n_checks++;
        n_errors++;
        $error("FAIL run_timeout: observed no retire/halt/error expected one within 200 cycles");
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; mem_ack = 1'b0; ir = '0;
        clear_obs();
        @(negedge clk);

        // Reset state.
        do_reset();
        check("reset_flags", flags(), 9'h000);
        check("reset_cycle_cnt", cycle_cnt, 0);
        check("reset_instr_cnt", instr_cnt, 0);

        // Zero-wait program: addi, add, sw, lw, beq, halt.
        do_start();
        clear_obs();
        run_instr(I_ADDI, 0, 0); check("addi_cycles", cyc, 4);
        run_instr(I_ADD,  0, 0); check("add_cycles",  cyc, 4);
        run_instr(I_SW,   0, 0); check("sw_cycles",   cyc, 4);
        check("sw_store_cycles", wr_cnt, 1);
        run_instr(I_LW,   0, 0); check("lw_cycles",   cyc, 5);
        run_instr(I_BEQ,  0, 0); check("beq_cycles",  cyc, 3);
        run_instr(I_HALT, 0, 0); check("halt_cycles", cyc, 2);
        check("prog_done", done, 1'b1);
        check("prog_busy", busy, 1'b0);
        check("prog_cycle_cnt", cycle_cnt, 22);
        check("prog_instr_cnt", instr_cnt, 5);
        check("prog_pc_we_pulses", pc_pulses, 5);
        check("prog_reg_write_pulses", rw_pulses, 3);
        check("prog_ir_we_pulses", irwe_cnt, 6);
        check("sat_cycle_cnt", s_cycle_cnt, 15);
        check("sat_instr_cnt_5", s_instr_cnt, 5);
        step();
        check("halt_hold_cycle_cnt", cycle_cnt, 22);

        // Load with the data access acknowledged after 3 wait cycles.
        do_start();
        clear_obs();
        run_instr(I_LW, 0, 3);
        check("lw_wait_cycles", cyc, 8);
        check("lw_wait_mem_req_alu", mreq_cnt, 4);
        check("lw_wait_no_store", wr_cnt, 0);
        check("lw_wait_total_req", req_cnt, 5);
        check("restart_instr_cnt", instr_cnt, 1);
        check("lw_wait_cycle_cnt", cycle_cnt, 8);
        run_instr(I_HALT, 0, 0);
        check("lw_wait_halt_cnt", cycle_cnt, 10);

        // Fetch ack in the last permitted wait cycle is accepted.
        do_start();
        run_instr(I_ADDI, 14, 0);
        check("late_ack_cycles", cyc, 18);
        check("late_ack_no_err", err, 1'b0);
        check("late_ack_instr_cnt", instr_cnt, 1);
        run_instr(I_HALT, 0, 0);
        check("late_ack_done", done, 1'b1);

        // Fetch never acknowledged: timeout into ERROR.
        do_start();
        clear_obs();
        run_instr(I_ADDI, 1000, 0);
        check("timeout_busy_cycles", cyc, 15);
        check("timeout_req_cycles", req_cnt, 15);
        check("timeout_flags", flags(), 9'h001);
        check("timeout_cycle_cnt", cycle_cnt, 15);
        check("timeout_instr_cnt", instr_cnt, 0);
        start = 1'b1;
        step(); step(); step();
        start = 1'b0;
        #1;
        check("error_ignores_start", flags(), 9'h001);
        check("error_hold_cycle_cnt", cycle_cnt, 15);
        @(negedge clk);

        // Illegal opcode after one retired instruction.
        do_reset();
        check("reset_clears_err", flags(), 9'h000);
        do_start();
        run_instr(I_ADDI, 0, 0);
        run_instr(I_ILL, 0, 0);
        check("illegal_cycles", cyc, 2);
        check("illegal_err", err, 1'b1);
        check("illegal_instr_cnt", instr_cnt, 1);
        check("illegal_cycle_cnt", cycle_cnt, 6);

        // Reset in the middle of a store's data access.
        do_reset();
        do_start();
        ir = I_SW;
        mem_ack = 1'b1;
        #1;
        check("mid_fetch_ir_we", ir_we, 1'b1);
        @(negedge clk);
        mem_ack = 1'b0;
        step();                     // DECODE
        step();                     // EXEC
        #1;
        check("mid_mem_store_req", {mem_req, mem_wr, addr_sel}, 3'b111);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        mem_ack = 1'b1;             // no request outstanding: must be ignored
        #1;
        check("mid_reset_flags", flags(), 9'h000);
        check("mid_reset_cycle_cnt", cycle_cnt, 0);
        @(negedge clk);
        mem_ack = 1'b0;
        step();
        #1;
        check("mid_reset_idle", flags(), 9'h000);
        @(negedge clk);

        // Twenty-instruction loop; the 4-bit instance saturates.
        do_reset();
        do_start();
        for (int i = 0; i < 20; i++)
            run_instr(((i % 2) == 1) ? I_BEQ : I_ADDI, 0, 0);
        run_instr(I_HALT, 0, 0);
        check("loop_instr_cnt", instr_cnt, 20);
        check("loop_cycle_cnt", cycle_cnt, 72);
        check("loop_sat_instr_cnt", s_instr_cnt, 15);
        check("loop_sat_cycle_cnt", s_cycle_cnt, 15);
        check("loop_sat_done", s_done, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/riscv_mc_sequencer.md
# riscv_mc_sequencer

Parametrised multi-cycle control sequencer for the RISC-V core. It replaces the single-cycle top's implicit one-instruction-per-clock flow with an explicit FSM. The FSM steps each instruction through FETCH/DECODE/EXEC/MEM/WB over one shared, variable-latency memory port with a req/ack handshake. It sits between the combinational decoder/datapath and the unified memory, and adds the following:

- a halt on an all-zero instruction (`done`)
- a memory-timeout error
- saturating cycle and retired-instruction counters

## Interface
- `XLEN`, default 32: instruction/register width; the halt check compares all `XLEN` bits of `ir`.
- `CNT_W`, default 32: width of `cycle_cnt` and `instr_cnt`.
- `MAX_WAIT`, default 15: maximum number of cycles `mem_req` may be held without `mem_ack`; must be ≥1.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-low; when `rst`=0 at a rising edge, all state is cleared.
- `start`  in  1: starts execution from IDLE or HALT.
- `ir`  in  `XLEN`: instruction-register contents, valid from DECODE onward.
- `mem_ack`  in  1: memory completion; sampled only while `mem_req`=1.
- `mem_req`  out  1: memory access request.
- `mem_wr`  out  1: 1 = store access; qualified by `mem_req`.
- `addr_sel`  out  1: memory address select; 0 = PC, 1 = ALU result.
- `ir_we`  out  1: instruction-register load pulse.
- `pc_we`  out  1: PC update pulse; exactly one per retired instruction.
- `reg_write`  out  1: register-file write pulse.
- `busy`  out  1: high in FETCH, DECODE, EXEC, MEM and WB.
- `done`  out  1: high in HALT.
- `err`  out  1: high in ERROR.
- `cycle_cnt`  out  `CNT_W`: count of busy cycles.
- `instr_cnt`  out  `CNT_W`: count of retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR. State after reset: IDLE.
- IDLE: leaves on `start`=1, going to FETCH; counters are cleared on that edge.
- FETCH: `mem_req`=1, `mem_wr`=0, `addr_sel`=0.
  - On `mem_ack`: `ir_we`=1 in that cycle, next state DECODE.
- DECODE: selects the next state from `ir`.
  - `ir`==0 → HALT.
  - `ir[6:0]` in {0000011 load, 0100011 store, 0110011 R-type, 0010011 I-ALU, 0110111 lui, 1101111 jal, 1100111 jalr, 1100011 branch} → EXEC.
  - Any other opcode → ERROR.
- EXEC:
  - Branch: `pc_we`=1, next state FETCH.
  - Load/store: next state MEM.
  - All others: next state WB.
- MEM: `mem_req`=1, `addr_sel`=1; `mem_wr`=1 for store, 0 for load.
  - Load + `mem_ack` → WB.
  - Store + `mem_ack` → `pc_we`=1 in that cycle, next state FETCH.
- WB: `reg_write`=1 and `pc_we`=1, next state FETCH.
- HALT: `done`=1.
  - `start`=1 clears both counters and goes to FETCH.
  - Otherwise stays in HALT.
- Memory timeout: a wait counter runs while in FETCH or MEM without `mem_ack`.
  - It clears on every state change.
  - If `MAX_WAIT` consecutive cycles elapse without `mem_ack`, the next state is ERROR.
  - `mem_ack` arriving in the `MAX_WAIT`-th cycle is accepted and has priority over the timeout.
- ERROR: `err`=1, all request/enable outputs 0, `start` ignored; exited only by reset.
- Counters:
  - `cycle_cnt` increments on every cycle with `busy`=1.
  - `instr_cnt` increments on every `pc_we` pulse.
  - Both saturate at 2^`CNT_W`−1 and never wrap.
  - Both hold their value in HALT and ERROR.

## Timing
- Outputs are decoded from the current state (Moore), except `ir_we` and the store-path `pc_we`, which are gated by `mem_ack` in the same cycle (Mealy).
- `mem_ack` may be asserted in the first cycle of `mem_req`; zero-wait access therefore costs one cycle.
- Zero-wait cycle counts per instruction:
  - Branch: 3 (FETCH, DECODE, EXEC).
  - R/I/lui/jal/jalr: 4.
  - Store: 4.
  - Load: 5.
- Each wait cycle adds 1 to these counts.
- `mem_req` stays high continuously until the ack cycle and drops on the following edge.
- `mem_ack` while `mem_req`=0 is ignored.
- Reset values: state IDLE; `mem_req`, `mem_wr`, `addr_sel`, `ir_we`, `pc_we`, `reg_write`, `busy`, `done`, `err` all 0; both counters 0.
- `rst`=0 mid-access: on that edge the sequencer enters IDLE and `mem_req` is 0 from the next cycle. The sequencer never issues a partial pulse afterwards.
- `start` held high across a whole program: it has effect only in IDLE or HALT; in HALT it restarts immediately.

## Test plan
- Zero-wait memory; program `addi`, `add`, `sw`, `lw`, `beq`, 0 → `done`=1 after 4+4+4+5+3+2 = 22 busy cycles; `instr_cnt`=5, `cycle_cnt`=22; exactly 5 `pc_we` and 3 `reg_write` pulses.
- `lw` with `mem_ack` delayed 3 cycles on the MEM access → `mem_req` held for 4 cycles with `addr_sel`=1, `mem_wr`=0; instruction takes 8 cycles.
- `mem_ack` never asserted in FETCH with `MAX_WAIT`=15 → ERROR after 15 cycles of `mem_req`; `err`=1, `mem_req`=0; a later `start` has no effect.
- `mem_ack` arriving in the 15th wait cycle → access accepted, no ERROR.
- `ir`=32'h0000007F (illegal opcode) → ERROR after DECODE with `instr_cnt` unchanged.
- `rst`=0 during MEM of a store → next cycle all outputs 0, state IDLE; with `CNT_W`=4 and a 20-instruction loop, `instr_cnt` saturates at 15.
